// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns an M-stage load/store into a word-aligned
// request/ready bus transaction, stalls the pipeline until it completes, and formats load data.
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_WAIT      = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     mem_readM_i,
    input  logic                     mem_writeM_i,
    input  logic [2:0]               funct3M_i,
    input  logic [ADDRESS_WIDTH-1:0] alu_resultM_i,
    input  logic [DATA_WIDTH-1:0]    write_dataM_i,
    output logic [DATA_WIDTH-1:0]    read_dataM_o,
    output logic                     stall_o,
    output logic                     fault_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    output logic [3:0]               mem_be_o,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
    input  logic                     mem_ready_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int            CW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    logic [1:0]               r_state;
    logic [CW-1:0]            r_cnt;
    logic [2:0]               r_funct3;
    logic [1:0]               r_off;
    logic                     r_req;
    logic                     r_we;
    logic                     r_fault;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [3:0]               r_be;
    logic [DATA_WIDTH-1:0]    r_read;

    logic                  w_access;
    logic                  w_f3_ok;
    logic                  w_align_ok;
    logic                  w_valid;
    logic                  w_illegal;
    logic [1:0]            w_a_lo;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_load;

    assign w_a_lo   = alu_resultM_i[1:0];
    assign w_access = mem_readM_i | mem_writeM_i;

    // Access legality: direction, funct3 encoding and natural alignment.
    always_comb begin
        w_f3_ok = 1'b0;
        if (mem_readM_i) begin
            case (funct3M_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end else if (mem_writeM_i) begin
            case (funct3M_i)
                3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
                default:                w_f3_ok = 1'b0;
            endcase
        end
        case (funct3M_i[1:0])
            2'b00:   w_align_ok = 1'b1;
            2'b01:   w_align_ok = ~w_a_lo[0];
            2'b10:   w_align_ok = (w_a_lo == 2'b00);
            default: w_align_ok = 1'b0;
        endcase
    end

    assign w_valid   = (mem_readM_i ^ mem_writeM_i) & w_f3_ok & w_align_ok;
    assign w_illegal = w_access & ~w_valid;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = write_dataM_i;
        case (funct3M_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_a_lo;
                w_wdata = {4{write_dataM_i[7:0]}};
            end
            2'b01: begin
                w_be    = w_a_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_dataM_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = write_dataM_i;
            end
        endcase
    end

    assign w_shifted = mem_rdata_i >> {r_off, 3'b000};

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load = {24'h000000, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load = {16'h0000, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_off    <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_fault  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_read   <= '0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_addr   <= {alu_resultM_i[ADDRESS_WIDTH-1:2], 2'b00};
                        r_we     <= mem_writeM_i;
                        r_be     <= mem_writeM_i ? w_be : 4'b0000;
                        r_wdata  <= w_wdata;
                        r_funct3 <= funct3M_i;
                        r_off    <= w_a_lo;
                        r_cnt    <= '0;
                        r_req    <= 1'b1;
                        r_state  <= S_REQ;
                    end else if (w_illegal) begin
                        r_fault <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        if (!r_we) r_read <= w_load;
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        // Timed-out load returns zero rather than stale data.
                        if (!r_we) r_read <= '0;
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Reset is folded in so the stall drops the instant reset is applied.
    assign stall_o = ~rst_i & (((r_state == S_IDLE) & w_valid) | (r_state == S_REQ));

    assign read_dataM_o = r_read;
    assign fault_o      = r_fault;
    assign mem_req_o    = r_req;
    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign mem_be_o     = r_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed accesses, a transaction-level
// expectation model checked every cycle, plus literal pins on key results.
module tb_load_store_unit;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr, ready;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    logic [31:0] read_data, mem_addr, mem_wdata;
    logic        stall, fault, mem_req, mem_we;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MW)) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_readM_i(rd), .mem_writeM_i(wr), .funct3M_i(f3),
        .alu_resultM_i(addr), .write_dataM_i(wd),
        .read_dataM_o(read_data), .stall_o(stall), .fault_o(fault),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .mem_rdata_i(rdata), .mem_ready_i(ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic        e_stall, e_req, e_fault, e_we, e_wck;
    logic [31:0] e_read, e_addr, e_wdata;
    logic [3:0]  e_be;
    bit          e_zero;
    bit          cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_legal(input bit r, input bit w, input logic [2:0] f, input logic [31:0] a);
        int sz;
        if (r == w) return 1'b0;
        if (w && f > 3'd2) return 1'b0;
        if (r && !(f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5)) return 1'b0;
        sz = 1 << f[1:0];
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input int off, input logic [31:0] word);
        int sz;
        logic [63:0] v, mask;
        sz   = 1 << f[1:0];
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = ({32'd0, word} >> (8 * off)) & mask;
        if (!f[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f, input int off);
        int sz;
        logic [3:0] be;
        sz = 1 << f[1:0];
        be = '0;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
        int sz;
        logic [31:0] r;
        sz = 1 << f[1:0];
        r  = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("stall", {31'd0, stall}, {31'd0, e_stall});
            chk("req",   {31'd0, mem_req}, {31'd0, e_req});
            chk("fault", {31'd0, fault}, {31'd0, e_fault});
            chk("read",  read_data, e_read);
            if (e_req) begin
                chk("addr", mem_addr, e_addr);
                chk("we",   {31'd0, mem_we}, {31'd0, e_we});
                chk("be",   {28'd0, mem_be}, {28'd0, e_be});
                if (e_wck) chk("wdata", mem_wdata, e_wdata);
            end else if (e_zero) begin
                chk("bus_zero", {mem_we, mem_be, 27'd0} | mem_addr | mem_wdata, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One M-stage access; ready_at is the REQ cycle index that sees mem_ready_i (-1 = never).
    task automatic access(input bit r, input bit w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] word, input int ready_at,
                          input bit ready_early, input bit lit_en, input logic [3:0] lit_be,
                          input logic [31:0] lit_wd);
        bit ok, timeout;
        ok = m_legal(r, w, f, a);
        rd = r; wr = w; f3 = f; addr = a; wd = d; rdata = word; ready = ready_early;
        e_stall = ok; e_req = 1'b0; e_fault = 1'b0;
        step();
        ready = 1'b0;
        if (!ok) begin
            rd = 1'b0; wr = 1'b0;
            e_fault = 1'b1;
            step();
            e_fault = 1'b0;
            step();
        end else begin
            e_zero  = 1'b0;
            e_req   = 1'b1;
            e_stall = 1'b1;
            e_addr  = {a[31:2], 2'b00};
            e_we    = w;
            e_be    = w ? m_be(f, int'(a[1:0])) : 4'b0000;
            e_wck   = w;
            e_wdata = m_wdata(f, d);
            if (lit_en) begin
                chk("lit_be", {28'd0, mem_be}, {28'd0, lit_be});
                chk("lit_wdata", mem_wdata, lit_wd);
            end
            timeout = 1'b0;
            for (int k = 0; ; k++) begin
                ready = (k == ready_at);
                step();
                if (k == ready_at) break;
                if (k == MW - 1) begin
                    timeout = 1'b1;
                    break;
                end
            end
            ready   = 1'b0;
            e_req   = 1'b0;
            e_stall = 1'b0;
            e_fault = timeout;
            if (r) e_read = timeout ? 32'd0 : m_load(f, int'(a[1:0]), word);
            step();
            rd = 1'b0; wr = 1'b0;
            e_fault = 1'b0;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; f3 = '0; addr = '0; wd = '0; rdata = '0; ready = 1'b0;
        e_stall = 1'b0; e_req = 1'b0; e_fault = 1'b0; e_read = '0; e_zero = 1'b1;
        e_we = 1'b0; e_wck = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
        #1;
        chk("rst_read", read_data, 32'd0);
        chk("rst_req",  {31'd0, mem_req}, 32'd0);
        cmp_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        ready = 1'b1;
        step();
        ready = 1'b0;
        step();

        access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 4'h0, 32'h0);
        chk("lw_lit", read_data, 32'hDEADBEEF);
        access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 0, 0, 4'h0, 32'h0);
        chk("lb_lit", read_data, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0, 0, 4'h0, 32'h0);
        chk("lbu_lit", read_data, 32'h00000080);
        access(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 2, 0, 1, 4'b1100, 32'hABCDABCD);
        chk("sh_read_kept", read_data, 32'h00000080);

        access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
        access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
        access(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
        access(0, 1, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
        access(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
        chk("illegal_read_kept", read_data, 32'h00000080);

        access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 0, 0, 0, 4'h0, 32'h0);
        chk("lh_lit", read_data, 32'hFFFF8001);
        access(1, 0, 3'b101, 32'h100, 32'h0, 32'h80017FFF, 1, 0, 0, 4'h0, 32'h0);
        access(1, 0, 3'b001, 32'h100, 32'h0, 32'h8001F00F, 0, 0, 0, 4'h0, 32'h0);
        access(0, 1, 3'b000, 32'h101, 32'h123456A5, 32'h0, 0, 0, 1, 4'b0010, 32'hA5A5A5A5);
        access(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 3, 0, 1, 4'b1111, 32'hCAFEF00D);
        access(1, 0, 3'b100, 32'h102, 32'h0, 32'h00AB0000, 1, 1, 0, 4'h0, 32'h0);
        chk("lbu_early_ready_lit", read_data, 32'h000000AB);

        access(1, 0, 3'b010, 32'h200, 32'h0, 32'h12345678, -1, 0, 0, 4'h0, 32'h0);
        chk("timeout_read_lit", read_data, 32'd0);
        access(1, 0, 3'b010, 32'h204, 32'h0, 32'h0BADF00D, 1, 0, 0, 4'h0, 32'h0);

        // Reset while the request is outstanding.
        rd = 1'b1; f3 = 3'b010; addr = 32'h300; rdata = 32'h55AA55AA; ready = 1'b0;
        e_stall = 1'b1; e_req = 1'b0;
        step();
        e_req = 1'b1; e_addr = 32'h300; e_we = 1'b0; e_be = 4'b0000; e_wck = 1'b0;
        step();
        #1;
        rst = 1'b1;
        e_req = 1'b0; e_stall = 1'b0; e_read = 32'd0; e_zero = 1'b1;
        #1;
        chk("rst_mid_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_read",  read_data, 32'd0);
        rd = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        access(1, 0, 3'b000, 32'h301, 32'h0, 32'h00007F00, 0, 0, 0, 4'h0, 32'h0);
        chk("post_rst_lb_lit", read_data, 32'h0000007F);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
